// File: rtl/vmem_pkg.sv
// Shared constants and types for the vector-memory write-port arbiter.
package vmem_pkg;

  localparam int VMEM_NREQ   = 5;
  localparam int VMEM_REQ_VS = VMEM_NREQ - 1;

  typedef logic [2:0] vmem_req_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } vmem_arb_state_t;

endpackage

// File: rtl/vmem_rr_pick.sv
// Rotate-priority picker: first set req bit at or after rr_ptr, wrapping at NREQ.
// Purely combinational; no backpressure.
module vmem_rr_pick
  import vmem_pkg::*;
#(
  parameter int NREQ  = VMEM_NREQ,
  parameter int SEL_W = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] idx
);

  localparam logic [SEL_W:0] NREQ_W = (SEL_W+1)'(NREQ);

  logic [SEL_W:0] cand;
  logic           found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // rr_ptr < NREQ, so one conditional subtract implements the wrap
      cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vmem_wr_arb.sv
// Round-robin burst arbiter for the vmem write port; grant one cycle after IDLE req, beats pass through m_valid/m_ready.
// Grant held across m_ready or req stalls; VMEM_ARB_VS_PRIO_EN gives the vector store fixed priority.
module vmem_wr_arb
  import vmem_pkg::*;
#(
  parameter int NREQ      = VMEM_NREQ,
  parameter int SEL_W     = 3,
  parameter int BURST_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  last,
  output logic [NREQ-1:0]  ack,
  output logic [NREQ-1:0]  gnt,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SEL_W-1:0] m_sel,
  output logic             m_last,
  output logic             busy
);

  localparam logic [7:0]       BEAT_LAST = 8'(BURST_MAX - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NREQ - 1);

  vmem_arb_state_t  state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;

  logic [NREQ-1:0]  pick_gnt, arb_gnt;
  logic [SEL_W-1:0] pick_idx, arb_idx, next_ptr;
  logic             xfer, at_limit, burst_end;

  vmem_rr_pick #(
    .NREQ  (NREQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  always_comb begin
    arb_gnt  = pick_gnt;
    arb_idx  = pick_idx;
    next_ptr = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
`ifdef VMEM_ARB_VS_PRIO_EN
    if (req[NREQ-1]) begin
      arb_gnt           = '0;
      arb_gnt[NREQ-1]   = 1'b1;
      arb_idx           = LAST_IDX;
    end
    // vector-store bursts leave the idma rotation where it was
    if (sel_q == LAST_IDX) next_ptr = rr_ptr_q;
`endif
  end

  assign busy      = (state_q == BURST);
  assign m_valid   = busy & req[sel_q];
  assign xfer      = m_valid & m_ready;
  assign at_limit  = (beat_cnt_q == BEAT_LAST);
  assign m_last    = m_valid & (last[sel_q] | at_limit);
  assign burst_end = xfer & (last[sel_q] | at_limit);
  assign ack       = gnt_q & {NREQ{xfer}};
  assign gnt       = gnt_q;
  assign m_sel     = sel_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = BURST;
          gnt_d      = arb_gnt;
          sel_d      = arb_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_d    = IDLE;
          gnt_d      = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = next_ptr;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_vmem_wr_arb.sv
// Directed and randomized bench for vmem_wr_arb against a burst-level reference model.
module tb_vmem_wr_arb;

  localparam int N  = 5;
  localparam int BM = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, last, ack, gnt;
  logic         m_valid, m_ready, m_last, busy;
  logic [2:0]   m_sel;

  int tests = 0;
  int fails = 0;

  // reference model: current owner (-1 = idle), beats done, rotation pointer
  int own    = -1;
  int nbeats = 0;
  int ptr    = 0;

  always #5 clk = ~clk;

  vmem_wr_arb #(.NREQ(N), .SEL_W(3), .BURST_MAX(BM)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .last    (last),
    .ack     (ack),
    .gnt     (gnt),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sel   (m_sel),
    .m_last  (m_last),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [N-1:0] eg;
    logic         mv;
    @(negedge clk);
    eg = '0;
    mv = 1'b0;
    if (own >= 0) begin
      eg[own] = 1'b1;
      mv      = req[own];
    end
    check("m_busy",   32'(busy),    32'(own >= 0));
    check("m_gnt",    32'(gnt),     32'(eg));
    check("m_valid",  32'(m_valid), 32'(mv));
    check("m_ack",    32'(ack),     32'((mv && m_ready) ? eg : '0));
    check("m_last",   32'(m_last),  32'(mv && (last[own] || nbeats == BM - 1)));
    if (own >= 0) check("m_sel", 32'(m_sel), 32'(own));
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      own = -1; nbeats = 0; ptr = 0;
    end else if (own < 0) begin
      if (req != '0) begin
`ifdef VMEM_ARB_VS_PRIO_EN
        if (req[N-1]) own = N - 1; else
`endif
        for (int k = 0; k < N; k++)
          if (own < 0 && req[(ptr + k) % N]) own = (ptr + k) % N;
      end
    end else if (req[own] && m_ready) begin
      nbeats++;
      if (last[own] || nbeats == BM) begin
`ifdef VMEM_ARB_VS_PRIO_EN
        if (own != N - 1)
`endif
        ptr = (own + 1) % N;
        own = -1;
        nbeats = 0;
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; last = '0; m_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; req = '0; last = '0; m_ready = 1'b0;
    advance(); advance();
    reset = 1'b0;

    // reset state
    sample();
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt",  32'(gnt), 0);
    check("rst_ack",  32'(ack), 0);
    check("rst_mv",   32'(m_valid), 0);
    check("rst_ml",   32'(m_last), 0);
    check("rst_ptr",  32'(dut.rr_ptr_q), 0);
    advance();

    // single 3-beat burst from requester 0
    req = 5'b00001; m_ready = 1'b1;
    sample(); check("t1_idle", 32'(busy), 0); advance();
    sample(); check("t1_gnt", 32'(gnt), 32'h01); check("t1_ack1", 32'(ack), 32'h01);
    check("t1_ml1", 32'(m_last), 0); advance();
    sample(); check("t1_ack2", 32'(ack), 32'h01); advance();
    last = 5'b00001;
    sample(); check("t1_ack3", 32'(ack), 32'h01); check("t1_ml3", 32'(m_last), 1); advance();
    req = '0; last = '0;
    sample(); check("t1_bubble", 32'(busy), 0); check("t1_ptr", 32'(dut.rr_ptr_q), 1); advance();

    // all requesters, 1-beat bursts, round-robin order
    do_reset();
    req = 5'b11111; last = 5'b11111; m_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      sample(); check("t2_idle", 32'(busy), 0); advance();
      sample(); check("t2_gnt", 32'(gnt), 32'(1 << (g % N))); check("t2_ack", 32'(ack), 32'(1 << (g % N))); advance();
    end

    // forced release at BURST_MAX, then rotation to requester 3
    do_reset();
    req = 5'b01100; last = '0; m_ready = 1'b1;
    sample(); advance();
    n = 0;
    for (int i = 0; i < BM; i++) begin
      sample();
      if (ack[2]) n++;
      check("t3_ack3", 32'(ack[3]), 0);
      check("t3_ml", 32'(m_last), 32'(i == BM - 1));
      advance();
    end
    check("t3_nack", n, BM);
    sample(); check("t3_bubble", 32'(busy), 0); advance();
    sample(); check("t3_next", 32'(gnt), 32'h08); advance();

    // m_ready stall then req drop inside a burst
    do_reset();
    req = 5'b00010; last = '0; m_ready = 1'b1;
    sample(); advance();
    sample(); check("t4_ack", 32'(ack), 32'h02); advance();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(); check("t4_st_ack", 32'(ack), 0); check("t4_st_gnt", 32'(gnt), 32'h02);
      check("t4_st_cnt", 32'(dut.beat_cnt_q), 1); advance();
    end
    m_ready = 1'b1; req = '0;
    for (int i = 0; i < 2; i++) begin
      sample(); check("t4_dr_mv", 32'(m_valid), 0); check("t4_dr_gnt", 32'(gnt), 32'h02);
      check("t4_dr_cnt", 32'(dut.beat_cnt_q), 1); advance();
    end
    req = 5'b00010; last = 5'b00010;
    sample(); check("t4_end_ack", 32'(ack), 32'h02); check("t4_end_ml", 32'(m_last), 1); advance();
    req = '0; last = '0;
    sample(); check("t4_done", 32'(busy), 0); advance();

    // reset in the middle of a burst
    do_reset();
    req = 5'b00100; m_ready = 1'b1;
    sample(); advance();
    for (int i = 0; i < 5; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; req = 5'b11111;
    sample();
    check("t5_gnt", 32'(gnt), 0); check("t5_busy", 32'(busy), 0); check("t5_ack", 32'(ack), 0);
    check("t5_mv", 32'(m_valid), 0); check("t5_ml", 32'(m_last), 0);
    advance();
    sample(); check("t5_fresh", 32'(gnt), 32'h01); advance();

    // rr_ptr=1 with requesters 1 and 4 pending
    do_reset();
    req = 5'b00001; last = 5'b00001; m_ready = 1'b1;
    cyc(); cyc();
    req = 5'b10010; last = 5'b10010;
    sample(); advance();
`ifdef VMEM_ARB_VS_PRIO_EN
    sample(); check("t6_first", 32'(gnt), 32'h10); advance();
    sample(); advance();
    sample(); check("t6_second", 32'(gnt), 32'h02); advance();
`else
    sample(); check("t6_first", 32'(gnt), 32'h02); advance();
    sample(); advance();
    sample(); check("t6_second", 32'(gnt), 32'h10); advance();
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req     = 5'($urandom);
      last    = 5'($urandom & $urandom);
      m_ready = ($urandom % 4) != 0;
      reset   = ($urandom % 256) == 0;
      cyc();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vmem_wr_arb.md
# vmem_wr_arb

Round-robin burst arbiter that shares the single vector-memory write port among several requesters: the input-DMA channels and the vector-store path. Each requester raises a level `req` and marks its final beat with `last`. The arbiter grants one requester at a time and holds the grant for the whole burst. While a burst is granted it forwards that requester's valid/ready handshake to the memory port. It sits between the DMA/vector-store request fabric and the vmem controller's write side.

## Interface
Parameters:
- `NREQ`, 5: number of requesters (0..3 = idma channels, NREQ-1 = vector store).
- `SEL_W`, 3: width of `m_sel`; must satisfy 2^SEL_W >= NREQ.
- `BURST_MAX`, 16: beat limit after which a grant is forcibly released (1..255).

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `req`  in  NREQ  — per-requester valid for the current beat.
- `last`  in  NREQ  — per-requester end-of-burst marker; qualified by `req`.
- `ack`  out  NREQ  — per-requester beat accepted this cycle.
- `gnt`  out  NREQ  — one-hot grant owner; all zero when idle.
- `m_valid`  out  1  — beat valid toward the vmem write port.
- `m_ready`  in  1  — vmem write port accepts the beat.
- `m_sel`  out  SEL_W  — index of the granted requester (datapath mux select).
- `m_last`  out  1  — final beat of the burst, either from `last` or from the forced limit.
- `busy`  out  1  — a burst is in progress.

## Operation
- States: IDLE and BURST.
- IDLE:
  - If any `req` bit is high, select the first requester at or after `rr_ptr`, searching in increasing index and wrapping from NREQ-1 to 0.
  - Register `gnt`/`m_sel` and go to BURST.
  - If no `req` bit is high, stay in IDLE.
- BURST:
  - `m_valid = req[m_sel]`.
  - `ack[i] = gnt[i] & m_valid & m_ready`.
  - A transfer occurs when `m_valid & m_ready`; each transfer increments `beat_cnt` (8-bit).
- Burst end: on a transfer where `last[m_sel]` is high or `beat_cnt == BURST_MAX-1`.
  - Set `rr_ptr = (m_sel+1) mod NREQ`.
  - Clear `gnt` and `beat_cnt`, go to IDLE.
- `m_last = m_valid & (last[m_sel] | beat_cnt == BURST_MAX-1)`.
- Requester drops `req` mid-burst: `m_valid` goes low, the grant is held and no beat is counted. The arbiter waits indefinitely.
- Requests from non-granted requesters are ignored until the next IDLE cycle; their `ack` stays 0.
- `last` without `req` is ignored.
- `rr_ptr` wraps modulo NREQ. NREQ values that are not powers of two are legal.
- Reset mid-burst aborts the burst. No further `ack` is issued, and the requester must re-request.

## Timing
- Reset values: state IDLE, `gnt=0`, `m_sel=0`, `rr_ptr=0`, `beat_cnt=0`. Outputs `m_valid=0`, `ack=0`, `m_last=0`, `busy=0`.
- Arbitration latency: `req` sampled high in IDLE at cycle N gives `gnt`/`busy` at N+1. The first beat can transfer at N+1.
- `ack`, `m_valid` and `m_last` are combinational from `req`, `last`, `m_ready` and registered state. There is no combinational path from `m_ready` to `gnt`.
- Exactly one IDLE bubble cycle separates consecutive bursts.
- Maximum wait for a continuously requesting requester: (NREQ-1)·(BURST_MAX+1) cycles plus its own IDLE cycle, provided `m_ready` is held high.

## Configuration
- `VMEM_ARB_VS_PRIO_EN` defined:
  - Requester NREQ-1 (vector store) wins any IDLE arbitration in which its `req` is high, regardless of `rr_ptr`.
  - `rr_ptr` is not updated after a vector-store burst.
  - Round-robin among 0..NREQ-2 is otherwise unchanged.
- Not defined: pure round-robin over all NREQ requesters, as described above.

## Structure
- Shared package `vmem_pkg`:
  - `VMEM_NREQ` and `VMEM_REQ_VS` index constants.
  - Requester index typedef `vmem_req_idx_t`.
  - State enum `vmem_arb_state_t` with values IDLE and BURST.
- One sub-module, `vmem_rr_pick`: purely combinational rotate-priority picker. Inputs `req` and `rr_ptr`; outputs a one-hot grant and an index. It is instantiated once.
- Counter, FSM and handshake logic stay in `vmem_wr_arb`.

## Test plan
- Reset, then `req=5'b00001`, `m_ready=1`, `last` on the 3rd beat → `gnt=00001` from cycle 1, `ack[0]` on 3 consecutive cycles, `m_last` on the 3rd, then `busy=0` for one cycle and `rr_ptr=1`.
- All five requesters hold `req` with `last` on every beat and `m_ready=1` → grants in order 0,1,2,3,4,0, each 1 beat, separated by one IDLE cycle.
- Requester 2 holds `req` with no `last`, `BURST_MAX=16` → exactly 16 `ack[2]` pulses, `m_last` on the 16th, then the grant moves to the next requester.
- During a granted burst, `m_ready=0` for 4 cycles and then `req[1]` drops for 2 cycles → no `ack`, `beat_cnt` frozen, `gnt` held, and the burst completes when both recover.
- Assert `reset` after the 5th beat of a 10-beat burst → next cycle all outputs are zero, and a fresh request is granted starting from index 0.
- With `VMEM_ARB_VS_PRIO_EN`, `rr_ptr=1`, and `req=5'b10010` in IDLE → requester 4 is granted first, then requester 1.
